// File: rtl/ascon_dec_output_collector.sv
// Collects the AEAD decryption core's bit-serial plaintext and tag, verifies the tag,
// and presents the plaintext (zeroed on tag failure) on a valid/ready result port.
module ascon_dec_output_collector #(
    parameter int unsigned y    = 64,
    parameter int unsigned SKIP = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           decryption_readyxSI,
    input  logic           plain_textxSI,
    input  logic           tagxSI,
    input  logic [127:0]   expected_tagxDI,
    input  logic           result_readyxSI,
    output logic [y-1:0]   plain_textxDO,
    output logic           tag_okxSO,
    output logic           result_validxSO,
    output logic           busyxSO,
    output logic           overrunxSO
);

    localparam int unsigned TAGW = 128;
    localparam int unsigned N    = (y > TAGW) ? y : TAGW;
    localparam int unsigned CW   = $clog2(N + 1);

    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
    localparam logic [CW-1:0] PT_END   = CW'(y);
    localparam logic [CW-1:0] TAG_END  = CW'(TAGW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_CHECK,
        S_HOLD
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic             prevReady;
    logic             readyRise;
    logic [3:0]       waitCnt;
    logic [CW-1:0]    bitIdx;
    logic [y-1:0]     ptShift;
    logic [TAGW-1:0]  tagShift;
    logic [TAGW-1:0]  expTag;

    assign readyRise = decryption_readyxSI & ~prevReady;
    assign busyxSO   = (state != S_IDLE);

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (readyRise) stateNext = (SKIP == 0) ? S_SHIFT : S_WAIT;
            S_WAIT:  if (waitCnt == 4'd1) stateNext = S_SHIFT;
            S_SHIFT: if (bitIdx == LAST_BIT) stateNext = S_CHECK;
            S_CHECK: stateNext = S_HOLD;
            S_HOLD:  if (result_readyxSI) stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= stateNext;
    end

    // prevReady resets to 1 so a ready level held through reset is not a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            prevReady       <= 1'b1;
            waitCnt         <= '0;
            bitIdx          <= '0;
            ptShift         <= '0;
            tagShift        <= '0;
            expTag          <= '0;
            plain_textxDO   <= '0;
            tag_okxSO       <= 1'b0;
            result_validxSO <= 1'b0;
            overrunxSO      <= 1'b0;
        end else begin
            prevReady <= decryption_readyxSI;
            if (readyRise && (state != S_IDLE)) overrunxSO <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (readyRise) begin
                        expTag   <= expected_tagxDI;
                        ptShift  <= '0;
                        tagShift <= '0;
                        bitIdx   <= '0;
                        waitCnt  <= 4'(SKIP);
                    end
                end
                S_WAIT: waitCnt <= waitCnt - 4'd1;
                S_SHIFT: begin
                    // LSB-first: shifting in at the MSB leaves bit 0 at index 0 after the last shift
                    bitIdx <= bitIdx + 1'b1;
                    if (bitIdx < PT_END)  ptShift  <= {plain_textxSI, ptShift[y-1:1]};
                    if (bitIdx < TAG_END) tagShift <= {tagxSI, tagShift[TAGW-1:1]};
                end
                S_CHECK: begin
                    tag_okxSO       <= (tagShift == expTag);
                    plain_textxDO   <= (tagShift == expTag) ? ptShift : '0;
                    result_validxSO <= 1'b1;
                end
                S_HOLD: if (result_readyxSI) result_validxSO <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_dec_output_collector.sv
// Directed bench for ascon_dec_output_collector: default (y=64, SKIP=2) and y=160/SKIP=0 instances.
module tb_ascon_dec_output_collector;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance
    logic         rdy0, pt0, tg0, rr0;
    logic [127:0] expTag0;
    logic [63:0]  ptOut0;
    logic         tagOk0, valid0, busy0, overrun0;

    // wide instance
    logic         rdy1, pt1, tg1, rr1;
    logic [127:0] expTag1;
    logic [159:0] ptOut1;
    logic         tagOk1, valid1, busy1, overrun1;

    int checks = 0;
    int errors = 0;

    ascon_dec_output_collector #(.y(64), .SKIP(2)) dut0 (
        .clk(clk), .rst(rst),
        .decryption_readyxSI(rdy0), .plain_textxSI(pt0), .tagxSI(tg0),
        .expected_tagxDI(expTag0), .result_readyxSI(rr0),
        .plain_textxDO(ptOut0), .tag_okxSO(tagOk0), .result_validxSO(valid0),
        .busyxSO(busy0), .overrunxSO(overrun0)
    );

    ascon_dec_output_collector #(.y(160), .SKIP(0)) dut1 (
        .clk(clk), .rst(rst),
        .decryption_readyxSI(rdy1), .plain_textxSI(pt1), .tagxSI(tg1),
        .expected_tagxDI(expTag1), .result_readyxSI(rr1),
        .plain_textxDO(ptOut1), .tag_okxSO(tagOk1), .result_validxSO(valid1),
        .busyxSO(busy1), .overrunxSO(overrun1)
    );

    typedef struct {
        logic [63:0]  pt;
        logic [127:0] tag;
        logic [127:0] expTag;
        logic         expOk;
        logic [63:0]  expPt;
    } vec_t;

    localparam logic [127:0] TAG_A  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] TAG_A77 = 128'h00112233445546778899AABBCCDDEEFF;
    localparam logic [63:0]  PT_A   = 64'h0123456789ABCDEF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full capture on dut0; ready stays high after t0 as a level
    task automatic runCapture(input string name, input logic [63:0] pt, input logic [127:0] tag,
                              input logic [127:0] expTag, input logic expOk, input logic [63:0] expPt,
                              input bit doOverrun, input int holdCycles);
        logic stable;
        rdy0 = 1'b0;
        step();
        expTag0 = expTag;
        rdy0 = 1'b1;
        step();                              // t0
        check({name, "_busy_t0"}, busy0, 1'b1);
        expTag0 = ~expTag;                   // must have been latched at t0
        step();
        step();
        for (int i = 0; i < 128; i++) begin
            pt0 = (i < 64) ? pt[i] : 1'b1;
            tg0 = tag[i];
            if (doOverrun && i == 46) rdy0 = 1'b0;
            if (doOverrun && i == 47) rdy0 = 1'b1;
            step();                          // edge t0+3+i
            if (doOverrun && i == 46) check({name, "_overrun_before"}, overrun0, 1'b0);
            if (doOverrun && i == 47) check({name, "_overrun_after"}, overrun0, 1'b1);
        end
        check({name, "_valid_early"}, valid0, 1'b0);
        step();                              // t0+131
        check({name, "_valid"}, valid0, 1'b1);
        check({name, "_tagok"}, tagOk0, expOk);
        check({name, "_pt"}, ptOut0, expPt);
        stable = 1'b1;
        for (int h = 0; h < holdCycles; h++) begin
            step();
            if (valid0 !== 1'b1 || tagOk0 !== expOk || ptOut0 !== expPt || busy0 !== 1'b1) stable = 1'b0;
        end
        if (holdCycles > 0) check({name, "_hold_stable"}, stable, 1'b1);
        rr0 = 1'b1;
        step();
        rr0 = 1'b0;
        check({name, "_valid_drop"}, valid0, 1'b0);
        check({name, "_idle"}, busy0, 1'b0);
        check({name, "_pt_kept"}, ptOut0, expPt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic [159:0] pt160;

        vecs[0] = '{PT_A, TAG_A, TAG_A, 1'b1, PT_A};
        vecs[1] = '{PT_A, TAG_A77, TAG_A, 1'b0, 64'h0};
        vecs[2] = '{64'h0, TAG_A, TAG_A, 1'b1, 64'h0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, '1, '1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{64'h8000_0000_0000_0001, TAG_A, TAG_A ^ 128'h1, 1'b0, 64'h0};

        // ready held high through reset must not start a capture
        rst = 1'b1;
        rdy0 = 1'b1; pt0 = 1'b0; tg0 = 1'b0; rr0 = 1'b0; expTag0 = '0;
        rdy1 = 1'b1; pt1 = 1'b0; tg1 = 1'b0; rr1 = 1'b0; expTag1 = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_busy", busy0, 1'b0);
        check("rst_valid", valid0, 1'b0);
        check("rst_tagok", tagOk0, 1'b0);
        check("rst_pt", ptOut0, 64'h0);
        check("rst_overrun", overrun0, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        step(); step(); step();
        check("no_start_held_ready", busy0, 1'b0);
        rdy1 = 1'b0;

        for (int v = 0; v < 5; v++) begin
            runCapture($sformatf("vec%0d", v), vecs[v].pt, vecs[v].tag, vecs[v].expTag,
                       vecs[v].expOk, vecs[v].expPt, 1'b0, 0);
            check($sformatf("vec%0d_no_overrun", v), overrun0, 1'b0);
        end

        runCapture("backpressure", PT_A, TAG_A, TAG_A, 1'b1, PT_A, 1'b0, 20);
        runCapture("overrun", PT_A, TAG_A, TAG_A, 1'b1, PT_A, 1'b1, 2);
        check("overrun_sticky", overrun0, 1'b1);

        // reset at t0+60 with ready held high
        rdy0 = 1'b0;
        step();
        expTag0 = TAG_A;
        rdy0 = 1'b1;
        step();
        for (int k = 1; k < 60; k++) begin
            pt0 = 1'b1; tg0 = 1'b1;
            step();
        end
        check("midshift_busy", busy0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", busy0, 1'b0);
        check("midrst_valid", valid0, 1'b0);
        check("midrst_tagok", tagOk0, 1'b0);
        check("midrst_pt", ptOut0, 64'h0);
        check("midrst_overrun", overrun0, 1'b0);
        for (int k = 0; k < 5; k++) step();
        check("midrst_no_start", busy0, 1'b0);
        runCapture("after_rst", PT_A, TAG_A, TAG_A, 1'b1, PT_A, 1'b0, 0);
        check("after_rst_overrun", overrun0, 1'b0);

        // y=160, SKIP=0: bit i sampled at t0+1+i, tag bits past 127 ignored
        pt160 = 160'hDEADBEEF_0123456789ABCDEF_FEDCBA9876543210;
        rdy1 = 1'b0;
        step();
        expTag1 = TAG_A;
        rdy1 = 1'b1;
        step();                              // t0
        for (int i = 0; i < 160; i++) begin
            pt1 = pt160[i];
            tg1 = (i < 128) ? TAG_A[i] : 1'b1;
            step();
        end
        check("wide_valid_early", valid1, 1'b0);
        step();                              // t0+161
        check("wide_valid", valid1, 1'b1);
        check("wide_tagok", tagOk1, 1'b1);
        check("wide_pt", ptOut1, pt160);
        rr1 = 1'b1;
        step();
        rr1 = 1'b0;
        check("wide_valid_drop", valid1, 1'b0);
        check("wide_idle", busy1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
